// File: rtl/usb_rx_wide.sv
// Full-speed USB receive path: bit recovery, NRZI/SYNC, unstuffing, EOP, word assembly.
// Latency: 2-flop input sync; RX_valid one cycle after the sample of a word's last bit.
// Backpressure: none; the consumer must take every RX_valid word; TX_en forces idle.
//
// Ports:
//   CLK, RST (async, active low)   DP, DM   line pins (asynchronous)
//   TX_en                          transmitter owns the line; receiver held idle
//   Data_o / ValidH                received word (LSB first bit) / upper byte valid
//   RX_valid, RX_error             one-cycle strobes;  RX_active  packet in progress
//   LineState                      synchronised {DM,DP}
module usb_rx_wide #(
    parameter int OVERSAMPLE = 4,
    parameter int DATA_WIDTH = 8,
    parameter int STUFF_LEN  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DP,
    input  logic                  DM,
    input  logic                  TX_en,
    output logic [DATA_WIDTH-1:0] Data_o,
    output logic                  ValidH,
    output logic                  RX_valid,
    output logic                  RX_active,
    output logic                  RX_error,
    output logic [1:0]            LineState
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_SMP   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DATA_WIDTH / 2);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    localparam logic [1:0]    LS_SE0   = 2'b00;
    localparam logic [1:0]    LS_J     = 2'b01;
    localparam logic [1:0]    LS_K     = 2'b10;

    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ABORT} state_t;

    logic [1:0]            meta_q, line_q, line_p_q, sym_q, sym_d;
    logic [PW-1:0]         phase_q, phase_d;
    state_t                state_q, state_d;
    logic [2:0]            sync_cnt_q, sync_cnt_d;
    logic [OW-1:0]         ones_q, ones_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
    logic                  validh_q, validh_d;
    logic                  rx_valid_q, rx_valid_d, rx_error_q, rx_error_d;
    logic                  rx_active_q, rx_active_d, abort_se0_q, abort_se0_d;
    logic                  edge_det, smp, is_jk, nrzi_bit;

    always_comb begin
        // Any line change re-centres the sampling phase on the new symbol.
        edge_det = (line_q != line_p_q);
        smp      = !edge_det && (phase_q == PH_SMP);
        is_jk    = (line_q == LS_J) || (line_q == LS_K);
        nrzi_bit = (line_q == sym_q);
        phase_d  = (edge_det || phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        // Only J/K samples update the NRZI reference; SE0/SE1 are not decoded.
        sym_d    = (smp && is_jk) ? line_q : sym_q;

        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        validh_d    = validh_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;
        rx_active_d = rx_active_q;
        abort_se0_d = abort_se0_q;

        if (TX_en) begin
            state_d     = ST_IDLE;
            rx_active_d = 1'b0;
            bit_cnt_d   = '0;
            ones_d      = '0;
            sync_cnt_d  = '0;
            abort_se0_d = 1'b0;
        end else if (smp) begin
            case (state_q)
                ST_IDLE: begin
                    // A K following J idle is the first SYNC bit (a 0).
                    if (line_q == LS_K && sym_q == LS_J) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk) begin
                        state_d = ST_IDLE;
                    end else if (sync_cnt_q == 3'd7) begin
                        if (nrzi_bit) begin
                            state_d     = ST_DATA;
                            rx_active_d = 1'b1;
                            ones_d      = '0;
                            bit_cnt_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (nrzi_bit) begin
                        state_d = ST_IDLE;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (line_q == LS_SE0) begin
                        state_d = ST_EOP;
                    end else if (is_jk) begin
                        if (ones_q == ONES_MAX) begin
                            // Stuffed position: a 0 is dropped, a 1 is a violation.
                            ones_d = '0;
                            if (nrzi_bit) begin
                                rx_error_d  = 1'b1;
                                state_d     = ST_ABORT;
                                abort_se0_d = 1'b0;
                            end
                        end else begin
                            ones_d  = nrzi_bit ? ones_q + 1'b1 : '0;
                            shreg_d = {nrzi_bit, shreg_q[DATA_WIDTH-1:1]};
                            if (bit_cnt_q == CNT_LAST) begin
                                data_d     = shreg_d;
                                validh_d   = 1'b1;
                                rx_valid_d = 1'b1;
                                bit_cnt_d  = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (line_q == LS_J) begin
                        state_d     = ST_IDLE;
                        rx_active_d = 1'b0;
                        bit_cnt_d   = '0;
                        // A half word sits in the upper half of the shifter.
                        if (DATA_WIDTH == 16 && bit_cnt_q == CNT_HALF) begin
                            data_d[7:0] = shreg_q[DATA_WIDTH-1 -: 8];
                            validh_d    = 1'b0;
                            rx_valid_d  = 1'b1;
                        end else if (bit_cnt_q != '0) begin
                            rx_error_d = 1'b1;
                        end
                    end else if (line_q == LS_K) begin
                        rx_error_d  = 1'b1;
                        state_d     = ST_ABORT;
                        abort_se0_d = 1'b0;
                    end
                end
                ST_ABORT: begin
                    if (line_q == LS_SE0) begin
                        abort_se0_d = 1'b1;
                    end else if (line_q == LS_J && abort_se0_q) begin
                        state_d     = ST_IDLE;
                        rx_active_d = 1'b0;
                        abort_se0_d = 1'b0;
                        bit_cnt_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            meta_q      <= '0;
            line_q      <= '0;
            line_p_q    <= '0;
            phase_q     <= '0;
            sym_q       <= '0;
            state_q     <= ST_IDLE;
            sync_cnt_q  <= '0;
            ones_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            validh_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
            rx_active_q <= 1'b0;
            abort_se0_q <= 1'b0;
        end else begin
            meta_q      <= {DM, DP};
            line_q      <= meta_q;
            line_p_q    <= line_q;
            phase_q     <= phase_d;
            sym_q       <= sym_d;
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            validh_q    <= validh_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
            rx_active_q <= rx_active_d;
            abort_se0_q <= abort_se0_d;
        end
    end

    assign Data_o    = data_q;
    assign ValidH    = (DATA_WIDTH == 16) ? validh_q : 1'b1;
    assign RX_valid  = rx_valid_q;
    assign RX_error  = rx_error_q;
    assign RX_active = rx_active_q;
    assign LineState = line_q;
endmodule

// File: tb/tb_usb_rx_wide.sv
`timescale 1ns/1ps
module tb_usb_rx_wide;
    logic CLK = 1'b0;
    logic RST, DP, DM, TX_en;
    always #10 CLK = ~CLK;

    logic [7:0]  d8;  logic vh8,  v8,  a8,  e8;  logic [1:0] ls8;
    logic [15:0] d16; logic vh16, v16, a16, e16; logic [1:0] ls16;

    usb_rx_wide #(.OVERSAMPLE(4), .DATA_WIDTH(8), .STUFF_LEN(6)) u8 (
        .CLK(CLK), .RST(RST), .DP(DP), .DM(DM), .TX_en(TX_en),
        .Data_o(d8), .ValidH(vh8), .RX_valid(v8), .RX_active(a8),
        .RX_error(e8), .LineState(ls8));
    usb_rx_wide #(.OVERSAMPLE(4), .DATA_WIDTH(16), .STUFF_LEN(6)) u16 (
        .CLK(CLK), .RST(RST), .DP(DP), .DM(DM), .TX_en(TX_en),
        .Data_o(d16), .ValidH(vh16), .RX_valid(v16), .RX_active(a16),
        .RX_error(e16), .LineState(ls16));

    int n_chk = 0, n_fail = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Passive monitor: logs strobes and RX_active edges as seen on the falling edge.
    int cyc = 0, err8 = 0, err16 = 0, ovl = 0;
    logic [7:0]  w8_q[$];
    int          w8_cyc[$];
    int          rise8[$];
    logic [17:0] w16_q[$];   // {RX_active fell this cycle, ValidH, Data_o}
    logic a8_d = 1'b0, a16_d = 1'b0;
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            if (v8) begin w8_q.push_back(d8); w8_cyc.push_back(cyc); end
            if (e8) err8++;
            if (a8 && !a8_d) rise8.push_back(cyc);
            if (v16) w16_q.push_back({a16_d && !a16, vh16, d16});
            if (e16) err16++;
            if ((v8 && e8) || (v16 && e16)) ovl++;
        end
        a8_d = a8;
        a16_d = a16;
    end

    task automatic sym(input byte c);
        case (c)
            "J":     {DM, DP} = 2'b01;
            "K":     {DM, DP} = 2'b10;
            default: {DM, DP} = 2'b00;
        endcase
        repeat (4) @(negedge CLK);
    endtask
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) sym(s[i]);
    endtask

    typedef struct {
        string       name;
        string       syms;
        int          n8;  logic [63:0] d8;  int er8;
        int          n16; logic [63:0] d16; logic [3:0] vh16; int er16;
        int          rise; int lat;
    } vec_t;

    function automatic vec_t mk(input string nm, input string s, input int n8, input logic [63:0] dd8,
                                input int er8, input int n16, input logic [63:0] dd16,
                                input logic [3:0] vh, input int er16, input int rise);
        vec_t v;
        v.name = nm; v.syms = s; v.n8 = n8; v.d8 = dd8; v.er8 = er8;
        v.n16 = n16; v.d16 = dd16; v.vh16 = vh; v.er16 = er16; v.rise = rise; v.lat = 32;
        return v;
    endfunction

    // Reference model: random payload, stuffed + NRZI encoded from first principles;
    // expected words are simply consecutive LSB-first slices of the payload.
    function automatic vec_t mk_rand(input int k);
        vec_t v;
        logic [63:0] bits;
        int n, ones, nsym;
        bit biased, lvl_k;
        n = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 5) : $urandom_range(1, 40);
        biased = ($urandom_range(0, 1) == 1);
        bits = '0;
        for (int i = 0; i < n; i++)
            bits[i] = biased ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 1) == 1);
        v.name = $sformatf("rand%0d", k);
        v.syms = "KJKJKJKK";
        lvl_k = 1'b1; ones = 0; nsym = 0; v.lat = 0;
        for (int i = 0; i < n; i++) begin
            if (!bits[i]) lvl_k = !lvl_k;
            if (lvl_k) v.syms = {v.syms, "K"}; else v.syms = {v.syms, "J"};
            nsym++;
            if (i == 7) v.lat = nsym * 4;
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl_k = !lvl_k;
                if (lvl_k) v.syms = {v.syms, "K"}; else v.syms = {v.syms, "J"};
                nsym++;
                ones = 0;
            end
        end
        v.syms = {v.syms, "00J"};
        v.n8 = n / 8; v.d8 = bits; v.er8 = (n % 8 != 0) ? 1 : 0;
        v.n16 = n / 16 + ((n % 16 == 8) ? 1 : 0);
        v.d16 = bits;
        v.vh16 = '0;
        for (int i = 0; i < n / 16; i++) v.vh16[i] = 1'b1;
        v.er16 = (n % 16 != 0 && n % 16 != 8) ? 1 : 0;
        v.rise = 1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int b8, b16, be8, be16, br8, bo;
        logic [17:0] w;
        b8 = w8_q.size(); b16 = w16_q.size(); be8 = err8; be16 = err16;
        br8 = rise8.size(); bo = ovl;
        send(v.syms);
        send("JJJJ");
        check($sformatf("%s rx_valid count w8", v.name), w8_q.size() - b8, v.n8);
        for (int i = 0; i < v.n8 && b8 + i < w8_q.size(); i++)
            check($sformatf("%s w8 word%0d", v.name, i), w8_q[b8 + i], v.d8[8*i +: 8]);
        check($sformatf("%s rx_error count w8", v.name), err8 - be8, v.er8);
        check($sformatf("%s rx_valid count w16", v.name), w16_q.size() - b16, v.n16);
        for (int i = 0; i < v.n16 && b16 + i < w16_q.size(); i++) begin
            w = w16_q[b16 + i];
            check($sformatf("%s w16 validh%0d", v.name, i), w[16], v.vh16[i]);
            if (v.vh16[i]) begin
                check($sformatf("%s w16 word%0d", v.name, i), w[15:0], v.d16[16*i +: 16]);
            end else begin
                check($sformatf("%s w16 low%0d", v.name, i), w[7:0], v.d16[16*i +: 8]);
                check($sformatf("%s w16 active fall with last word", v.name), w[17], 1'b1);
            end
        end
        check($sformatf("%s rx_error count w16", v.name), err16 - be16, v.er16);
        check($sformatf("%s rx_active rises", v.name), rise8.size() - br8, v.rise);
        if (v.n8 > 0 && rise8.size() > br8 && w8_q.size() > b8)
            check($sformatf("%s first word latency", v.name), w8_cyc[b8] - rise8[br8], v.lat);
        check($sformatf("%s rx_active idle w8", v.name), a8, 1'b0);
        check($sformatf("%s rx_active idle w16", v.name), a16, 1'b0);
        check($sformatf("%s valid+error overlap", v.name), ovl - bo, 0);
    endtask

    vec_t vt[7];
    string SY, P1;

    initial begin
        int b8, b16, be8, be16;
        SY = "KJKJKJKK";
        P1 = {SY, "JJKKKJJK", "KKKKKKJKK", "JJKKKJJK", "00J"};
        vt[0] = mk("pkt3", P1, 3, 64'h5ABF5A, 0, 2, 64'h5ABF5A, 4'b0001, 0, 1);
        vt[1] = mk("stuff_err", {SY, "KKKKKKK", "00J"}, 0, 0, 1, 0, 0, 4'b0000, 1, 1);
        vt[2] = mk("align7", {SY, "KKJKKKK", "00J"}, 0, 0, 1, 0, 0, 4'b0000, 1, 1);
        vt[3] = mk("bad_sync", {"KJKJKKKK", "JJJJ"}, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        vt[4] = mk("one_byte", {SY, "JJKKKJJK", "00J"}, 1, 64'h5A, 0, 1, 64'h5A, 4'b0000, 0, 1);
        vt[5] = mk("two_byte", {SY, "JJKKKJJK", "KKKKKKJKK", "00J"}, 2, 64'hBF5A, 0,
                   1, 64'hBF5A, 4'b0001, 0, 1);
        vt[6] = mk("eop_k", {SY, "JJKKKJJK", "0K0J"}, 1, 64'h5A, 1, 0, 0, 4'b0000, 1, 1);

        RST = 1'b0; DP = 1'b1; DM = 1'b0; TX_en = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset data w8", d8, 8'h00);
        check("reset data w16", d16, 16'h0000);
        check("reset strobes", {v8, e8, a8, v16, e16, a16}, 6'b0);
        check("reset linestate", {ls8, ls16}, 4'b0000);
        check("reset validh w8 tied", vh8, 1'b1);
        check("reset validh w16", vh16, 1'b0);
        RST = 1'b1;
        send("JJJJ");
        check("linestate J", ls8, 2'b01);
        send("0");
        check("linestate SE0", ls16, 2'b00);
        send("JJJJ");

        foreach (vt[i]) apply(vt[i]);

        // Transmitter takes the line in the middle of the second byte.
        b8 = w8_q.size(); b16 = w16_q.size(); be8 = err8; be16 = err16;
        send({SY, "JJKKKJJK", "KKKK"});
        TX_en = 1'b1;
        @(negedge CLK);
        check("tx_en active w8", a8, 1'b0);
        check("tx_en active w16", a16, 1'b0);
        send("K");
        check("linestate K", ls8, 2'b10);
        send({"KJKK", "JJKKKJJK", "00J", "JJJJ"});
        TX_en = 1'b0;
        send("JJJJ");
        check("tx_en words w8", w8_q.size() - b8, 1);
        check("tx_en words w16", w16_q.size() - b16, 0);
        check("tx_en errors", (err8 - be8) + (err16 - be16), 0);
        apply(vt[0]);

        // Reset in the middle of a packet.
        send({SY, "JJKKKJJK", "KKK"});
        b8 = w8_q.size(); b16 = w16_q.size(); be8 = err8; be16 = err16;
        RST = 1'b0;
        #1;
        check("midreset data", {d8, d16}, 24'h0);
        check("midreset outputs", {v8, e8, a8, v16, e16, a16, ls8, ls16}, 10'b0);
        @(negedge CLK);
        {DM, DP} = 2'b01;
        @(negedge CLK);
        RST = 1'b1;
        send("JJJJJJ");
        check("midreset strobes", (w8_q.size() - b8) + (w16_q.size() - b16) +
                                  (err8 - be8) + (err16 - be16), 0);
        check("midreset idle", {a8, a16}, 2'b00);

        for (int k = 0; k < 20; k++) apply(mk_rand(k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
